branch_target_buffer: RTL

- Parametrised direct-mapped branch target buffer with per-entry saturating direction counters, for the next-generation pipelined CPU.
- Sits in IF: given the fetch PC, produces the predicted next PC, replacing the PC+4 / branch-target select.
- Trained from ID, where branches and jumps resolve. Keeps saturating lookup-hit and mispredict statistics.

---
 rtl/cpu_bp_pkg.sv | 22 ++
 rtl/branch_target_buffer_if.sv | 29 ++
 rtl/sat_counter.sv | 26 ++
 rtl/branch_target_buffer.sv | 108 ++++++++++
 4 files changed

// File: rtl/cpu_bp_pkg.sv
// Shared branch-predictor definitions: counter encodings, weak-state helpers
// and the sequential fetch increment.
package cpu_bp_pkg;

  localparam int PC_INC = 4;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Weak taken: MSB set, all lower bits clear.
  function automatic logic [31:0] weak_taken(input int width);
    return 32'(1) << (width - 1);
  endfunction

  // Weak not-taken: MSB clear, all lower bits set.
  function automatic logic [31:0] weak_not_taken(input int width);
    return (32'(1) << (width - 1)) - 32'(1);
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup / ID-training bus of the branch target buffer.
interface branch_target_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int STAT_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] pc_i;
  logic [ADDR_WIDTH-1:0] next_pc_o;
  logic                  pred_taken_o;
  logic                  upd_valid_i;
  logic [ADDR_WIDTH-1:0] upd_pc_i;
  logic                  upd_taken_i;
  logic [ADDR_WIDTH-1:0] upd_target_i;
  logic                  upd_pred_taken_i;
  logic                  flush_i;
  logic [STAT_WIDTH-1:0] hit_count_o;
  logic [STAT_WIDTH-1:0] mispredict_count_o;

  modport slave (
    input  pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, flush_i,
    output next_pc_o, pred_taken_o, hit_count_o, mispredict_count_o
  );

  modport master (
    output pc_i, upd_valid_i, upd_pc_i, upd_taken_i, upd_target_i,
           upd_pred_taken_i, flush_i,
    input  next_pc_o, pred_taken_o, hit_count_o, mispredict_count_o
  );
endinterface

// File: rtl/sat_counter.sv
// Registered saturating up/down counter with parallel load.
module sat_counter #(
  parameter int               WIDTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value
);

  always_ff @(posedge clk_i) begin
    if (rst_i)
      value <= RST_VAL;
    else if (load)
      value <= load_val;
    else if (inc && !dec && value != {WIDTH{1'b1}})
      value <= value + WIDTH'(1);
    else if (dec && !inc && value != {WIDTH{1'b0}})
      value <= value - WIDTH'(1);
  end

endmodule

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: same-cycle next-PC prediction in IF, registered training
// from ID, saturating hit/mispredict statistics.
module branch_target_buffer
  import cpu_bp_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CTR_WIDTH  = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  branch_target_buffer_if.slave bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_WT_G  = CTR_WIDTH'(weak_taken(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] CTR_WNT_G = CTR_WIDTH'(weak_not_taken(CTR_WIDTH));

  logic [ENTRIES-1:0]                 valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0]      tag_q;
  logic [ENTRIES-1:0][ADDR_WIDTH-1:0] target_q;
  logic [ENTRIES-1:0][CTR_WIDTH-1:0]  ctr_q;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = bus.pc_i[IDX_W+1:2];
  assign lk_tag = bus.pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign bus.pred_taken_o = lk_hit && ctr_q[lk_idx][CTR_WIDTH-1];
  assign bus.next_pc_o    = bus.pred_taken_o ? target_q[lk_idx]
                                             : bus.pc_i + ADDR_WIDTH'(PC_INC);

  // Update side; a flush suppresses all training in its cycle.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit, up_en, up_alloc, up_inc, up_dec, up_wr_tgt;

  assign up_idx    = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag    = bus.upd_pc_i[ADDR_WIDTH-1:IDX_W+2];
  assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_en     = bus.upd_valid_i && !bus.flush_i;
  assign up_alloc  = up_en && !up_hit && bus.upd_taken_i;
  assign up_inc    = up_en &&  up_hit && bus.upd_taken_i;
  assign up_dec    = up_en &&  up_hit && !bus.upd_taken_i;
  assign up_wr_tgt = up_en && bus.upd_taken_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      target_q <= '0;
    end else begin
      if (bus.flush_i)
        valid_q <= '0;
      else if (up_alloc)
        valid_q[up_idx] <= 1'b1;
      if (up_wr_tgt)
        target_q[up_idx] <= bus.upd_target_i;
    end
  end

  // Tags are only meaningful behind a valid bit, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && up_alloc)
      tag_q[up_idx] <= up_tag;
  end

  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = (up_idx == IDX_W'(e));

    sat_counter #(.WIDTH(CTR_WIDTH), .RST_VAL(CTR_WNT_G)) u_ctr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc     (sel && up_inc),
      .dec     (sel && up_dec),
      .load    (sel && up_alloc),
      .load_val(CTR_WT_G),
      .value   (ctr_q[e])
    );
  end

  sat_counter #(.WIDTH(STAT_WIDTH), .RST_VAL('0)) u_hit_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc     (lk_hit),
    .dec     (1'b0),
    .load    (1'b0),
    .load_val('0),
    .value   (bus.hit_count_o)
  );

  sat_counter #(.WIDTH(STAT_WIDTH), .RST_VAL('0)) u_mis_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc     (bus.upd_valid_i && (bus.upd_taken_i != bus.upd_pred_taken_i)),
    .dec     (1'b0),
    .load    (1'b0),
    .load_val('0),
    .value   (bus.mispredict_count_o)
  );

endmodule
